// File: rtl/maxpool_relu.sv
// -----------------------------------------------------------------------------
// maxpool_relu
//   Pooling stage that follows the convolution stage. On start it reads an
//   INPUT_X x INPUT_Y signed feature map (row-major) from the feature RAM,
//   takes the max over each non-overlapping POOL x POOL window, optionally
//   clamps negative results to zero, and writes the OUT_X x OUT_Y pooled map
//   (row-major) to the next-layer RAM before pulsing done.
//
// Ports:
//   clk      clock
//   rst      asynchronous active-high reset
//   start    begin one pooling pass (only looked at while idle)
//   data_rd  read data, valid one cycle after addr_rd
//   addr_rd  read address
//   data_wr  write data (registered, holds between writes)
//   addr_wr  write address (registered, holds between writes)
//   wren     write strobe, one cycle per output word
//   busy     high while a pass is in progress
//   done     one-cycle completion pulse
// -----------------------------------------------------------------------------
module maxpool_relu #(
    parameter int INPUT_X   = 8,
    parameter int INPUT_Y   = 8,
    parameter int POOL      = 2,
    parameter int BIT_WIDTH = 16,
    parameter int RAM_DEPTH = 64,
    parameter int RELU_EN   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [BIT_WIDTH-1:0]         data_rd,
    output logic [$clog2(RAM_DEPTH)-1:0] addr_rd,
    output logic [BIT_WIDTH-1:0]         data_wr,
    output logic [$clog2(RAM_DEPTH)-1:0] addr_wr,
    output logic                         wren,
    output logic                         busy,
    output logic                         done
);

    localparam int AW    = $clog2(RAM_DEPTH);
    localparam int OUT_X = INPUT_X / POOL;
    localparam int OUT_Y = INPUT_Y / POOL;
    localparam bit EMPTY = (OUT_X == 0) || (OUT_Y == 0);
    localparam int OXW   = (OUT_X > 1) ? $clog2(OUT_X) : 1;
    localparam int OYW   = (OUT_Y > 1) ? $clog2(OUT_Y) : 1;
    localparam int KW    = (POOL > 1) ? $clog2(POOL) : 1;

    typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, FIN} state_t;

    state_t                        state_reg, state_next;
    logic [OXW-1:0]                ox_reg, ox_next;
    logic [OYW-1:0]                oy_reg, oy_next;
    logic [KW-1:0]                 kr_reg, kr_next;   // row within window
    logic [KW-1:0]                 kc_reg, kc_next;   // column within window
    logic signed [BIT_WIDTH-1:0]   max_reg, max_next;
    // A read was issued last cycle, so data_rd carries a sample this cycle.
    logic                          rd_pend_reg, rd_pend_next;
    // That read was the first of its window: load instead of compare.
    logic                          rd_first_reg, rd_first_next;
    logic                          wren_reg, wren_next;
    logic [BIT_WIDTH-1:0]          data_wr_reg, data_wr_next;
    logic [AW-1:0]                 addr_wr_reg, addr_wr_next;

    logic signed [BIT_WIDTH-1:0]   data_rd_s;
    logic signed [BIT_WIDTH-1:0]   fold_val;
    int                            rd_addr_full;
    int                            wr_addr_full;

    assign data_rd_s    = $signed(data_rd);
    assign fold_val     = (rd_first_reg || (data_rd_s > max_reg)) ? data_rd_s : max_reg;
    assign rd_addr_full = (int'(oy_reg) * POOL + int'(kr_reg)) * INPUT_X
                        + int'(ox_reg) * POOL + int'(kc_reg);
    assign wr_addr_full = int'(oy_reg) * OUT_X + int'(ox_reg);

    assign wren    = wren_reg;
    assign data_wr = data_wr_reg;
    assign addr_wr = addr_wr_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            ox_reg       <= '0;
            oy_reg       <= '0;
            kr_reg       <= '0;
            kc_reg       <= '0;
            max_reg      <= '0;
            rd_pend_reg  <= 1'b0;
            rd_first_reg <= 1'b0;
            wren_reg     <= 1'b0;
            data_wr_reg  <= '0;
            addr_wr_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            ox_reg       <= ox_next;
            oy_reg       <= oy_next;
            kr_reg       <= kr_next;
            kc_reg       <= kc_next;
            max_reg      <= max_next;
            rd_pend_reg  <= rd_pend_next;
            rd_first_reg <= rd_first_next;
            wren_reg     <= wren_next;
            data_wr_reg  <= data_wr_next;
            addr_wr_reg  <= addr_wr_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        ox_next       = ox_reg;
        oy_next       = oy_reg;
        kr_next       = kr_reg;
        kc_next       = kc_reg;
        max_next      = max_reg;
        rd_pend_next  = 1'b0;
        rd_first_next = 1'b0;
        wren_next     = 1'b0;
        data_wr_next  = data_wr_reg;
        addr_wr_next  = addr_wr_reg;
        addr_rd       = '0;
        busy          = 1'b0;
        done          = 1'b0;

        // Fold whatever sample arrives this cycle, regardless of state.
        if (rd_pend_reg) begin
            max_next = fold_val;
        end

        case (state_reg)
            IDLE: begin
                if (start) begin
                    ox_next    = '0;
                    oy_next    = '0;
                    kr_next    = '0;
                    kc_next    = '0;
                    state_next = EMPTY ? FIN : READ;
                end
            end

            READ: begin
                busy          = 1'b1;
                addr_rd       = AW'(rd_addr_full);
                rd_pend_next  = 1'b1;
                rd_first_next = (kr_reg == '0) && (kc_reg == '0);
                if (int'(kc_reg) == POOL - 1) begin
                    kc_next = '0;
                    if (int'(kr_reg) == POOL - 1) begin
                        kr_next    = '0;
                        state_next = DRAIN;
                    end else begin
                        kr_next = kr_reg + 1'b1;
                    end
                end else begin
                    kc_next = kc_reg + 1'b1;
                end
            end

            DRAIN: begin
                // fold_val already includes the last sample of the window.
                busy         = 1'b1;
                wren_next    = 1'b1;
                addr_wr_next = AW'(wr_addr_full);
                data_wr_next = ((RELU_EN != 0) && (fold_val < 0)) ? '0 : fold_val;
                state_next   = WRITE;
            end

            WRITE: begin
                busy       = 1'b1;
                kr_next    = '0;
                kc_next    = '0;
                state_next = READ;
                if (int'(ox_reg) == OUT_X - 1) begin
                    ox_next = '0;
                    if (int'(oy_reg) == OUT_Y - 1) begin
                        oy_next    = '0;
                        state_next = FIN;
                    end else begin
                        oy_next = oy_reg + 1'b1;
                    end
                end else begin
                    ox_next = ox_reg + 1'b1;
                end
            end

            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: doc/maxpool_relu.md
Name: maxpool_relu

Overview:
- Pooling stage directly downstream of the convolution stage; same RAM-port style.
- On start, reads the convolution feature map (INPUT_X x INPUT_Y, row-major, signed) from the shared feature RAM.
- Computes the max over each non-overlapping POOL x POOL window and optionally applies ReLU.
- Writes the pooled map (OUT_X x OUT_Y, row-major) to the next-layer RAM, then pulses done.

Parameters:
- INPUT_X, 8, feature map width.
- INPUT_Y, 8, feature map height.
- POOL, 2, window edge and stride; must be >= 1.
- BIT_WIDTH, 16, sample width, two's-complement signed.
- RAM_DEPTH, 64, depth of the read and write RAMs; must be >= INPUT_X*INPUT_Y.
- RELU_EN, 1, 1 = clamp negative results to 0; 0 = pass max unchanged.
- Derived: OUT_X = INPUT_X/POOL and OUT_Y = INPUT_Y/POOL (floor). W = OUT_X*OUT_Y windows.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  begin one pooling pass; sampled only in IDLE
- data_rd  in  BIT_WIDTH  read data; valid exactly 1 cycle after addr_rd is presented
- addr_rd  out  $clog2(RAM_DEPTH)  read address
- data_wr  out  BIT_WIDTH  write data
- addr_wr  out  $clog2(RAM_DEPTH)  write address
- wren  out  1  write strobe, one cycle per output word
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle completion pulse

Interface (Already decided):
- One clock, clk.
- Reset rst is asynchronous and active-high.

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE; window counters and the running max are cleared.
  - addr_rd, addr_wr, data_wr, wren, busy and done are all 0.
  - Applies immediately, including mid-pass. The partial pass is abandoned; no further wren until a new start after rst deasserts.
- States: IDLE -> READ -> DRAIN -> WRITE -> (READ | FIN) -> IDLE.
- IDLE:
  - Outputs idle-valued, addr_rd = 0.
  - start = 1 -> READ; counters ox = oy = 0 and k = 0.
- READ:
  - For k = 0..POOL*POOL-1, one address per cycle: addr_rd = (oy*POOL + k/POOL)*INPUT_X + ox*POOL + k%POOL.
  - Row-within-window is the outer index.
  - Each data_rd arriving one cycle later is folded into the running max; the first sample of a window loads the max directly, with no compare against a stale value.
  - After issuing the last k -> DRAIN.
- DRAIN: folds the final data_rd sample -> WRITE.
- WRITE (one cycle):
  - wren = 1 and addr_wr = oy*OUT_X + ox.
  - data_wr = (RELU_EN && max < 0) ? 0 : max, with a signed compare.
  - Then advance ox; on ox == OUT_X-1, wrap ox to 0 and increment oy.
  - If the window just written is the last (ox = OUT_X-1, oy = OUT_Y-1) -> FIN, else -> READ with k = 0.
- FIN: done = 1 for exactly one cycle, busy = 0 -> IDLE.
- Timing:
  - Per window: POOL*POOL + 2 cycles.
  - done is high in cycle 1 + W*(POOL*POOL+2) counted after the edge that samples start.
  - Example: 4x4 input, POOL = 2 -> done in cycle 25.
- Output registers:
  - wren, data_wr and addr_wr are registered.
  - data_wr and addr_wr hold their last value when wren = 0.
- Width rules:
  - Max and compare are signed BIT_WIDTH; there is no widening and no saturation.
  - Addresses truncate to $clog2(RAM_DEPTH) bits; in-range by parameter constraint.
- Boundaries:
  - Trailing columns/rows beyond OUT_X*POOL / OUT_Y*POOL are never read.
  - Equal values: the max is that value.
  - start while busy is ignored; start held high across FIN begins a new pass on the cycle after done.
  - POOL = 1 degenerates to a ReLU copy at 3 cycles/word.
  - If OUT_X or OUT_Y is 0, start goes directly to FIN: done pulses once, no wren.

Test Plan:
1. 4x4, POOL=2, RELU_EN=1, RAM[i] = i (0..15), pulse start -> exactly 4 wren pulses: addr_wr 0,1,2,3 with data_wr 5,7,13,15; done in cycle 25; busy high cycles 1..24.
2. 4x4, POOL=2, window 0 = {-5,-1,-7,-2}, rest 0 -> RELU_EN=1: word0 = 0; RELU_EN=0: word0 = 16'hFFFF (-1).
3. Read-order check, 4x4 POOL=2 -> addr_rd sequence 0,1,4,5, 2,3,6,7, 8,9,12,13, 10,11,14,15.
4. 5x5, POOL=2, RAM[i] = i -> 4 outputs: 6,8,16,18; no addr_rd >= 20 and no address with column 4 ever issued.
5. start re-pulsed at cycle 7 of a pass -> ignored, output identical to scenario 1; start held high throughout -> second pass begins the cycle after done.
6. Async rst asserted mid-pass (during WRITE of window 1) -> wren/busy/done drop to 0 without waiting for a clock edge; after release, no activity until start; a fresh pass then reproduces scenario 1.
